dl_token_detect_unit: RTL and testbench

Per-process deadlock detector for the co-simulation deadlock-checking harness. One instance sits beside each dataflow process and produces that process's bit of the deadlock vector consumed by the deadlock report unit. Detection uses token passing: once its process has been blocked long enough, the instance circulates a process-ID token set along the channels it is blocked on, and declares deadlock when its own ID comes back. During reporting it receives `origin` and `token_clear` from the report unit and walks a one-hot report token around the circle, pulsing its output as the token passes through.

---
 rtl/dl_pkg.sv | 28 ++
 rtl/dl_token_detect_unit_if.sv | 28 ++
 rtl/dl_chan_merge.sv | 19 +
 rtl/dl_token_detect_unit.sv | 113 +++++++++++
 tb/tb_dl_token_detect_unit.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/dl_pkg.sv
// Shared types and helpers for the per-process token-passing deadlock detector.
package dl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ARMED,
        DETECTED
    } dl_state_e;

    localparam int unsigned FN_W = 32;

    // One-hot mask with bit `id` set; zero when id lies outside `width`.
    function automatic logic [FN_W-1:0] onehot(input int unsigned id, input int unsigned width);
        logic [FN_W-1:0] r;
        r = FN_W'(1) << id;
        if (id >= width || id >= FN_W) begin
            r = '0;
        end
        return r;
    endfunction

    // Isolates the lowest set bit as a one-hot mask; zero input gives zero.
    function automatic logic [FN_W-1:0] lowest_bit(input logic [FN_W-1:0] vec);
        return vec & (~vec + FN_W'(1));
    endfunction

endpackage

// File: rtl/dl_token_detect_unit_if.sv
// Detector-to-harness signal bundle: dependency inputs, detection tokens and report tokens.
interface dl_token_detect_unit_if #(
    parameter int unsigned PROC_NUM = 4,
    parameter int unsigned CHAN_NUM = 2
);
    logic                         proc_blocked;
    logic [CHAN_NUM-1:0]          dep_vec;
    logic [CHAN_NUM-1:0]          token_in_vld;
    logic [CHAN_NUM*PROC_NUM-1:0] token_in_data;
    logic [CHAN_NUM-1:0]          token_out_vld;
    logic [PROC_NUM-1:0]          token_out_data;
    logic [CHAN_NUM-1:0]          rpt_in_vld;
    logic [CHAN_NUM-1:0]          rpt_out_vld;
    logic [PROC_NUM-1:0]          origin;
    logic                         token_clear;
    logic                         dl_detect_out;

    // master: the harness/peers around a detector; slave: the detector itself
    modport master (
        output proc_blocked, dep_vec, token_in_vld, token_in_data, rpt_in_vld, origin, token_clear,
        input  token_out_vld, token_out_data, rpt_out_vld, dl_detect_out
    );

    modport slave (
        input  proc_blocked, dep_vec, token_in_vld, token_in_data, rpt_in_vld, origin, token_clear,
        output token_out_vld, token_out_data, rpt_out_vld, dl_detect_out
    );
endinterface

// File: rtl/dl_chan_merge.sv
// Combinational OR of the ID sets carried by all valid incoming detection channels.
module dl_chan_merge #(
    parameter int unsigned PROC_NUM = 4,
    parameter int unsigned CHAN_NUM = 2
) (
    input  logic [CHAN_NUM-1:0]          vld,
    input  logic [CHAN_NUM*PROC_NUM-1:0] data,
    output logic [PROC_NUM-1:0]          merged
);
    logic [PROC_NUM-1:0] acc [CHAN_NUM+1];

    assign acc[0] = '0;

    for (genvar c = 0; c < CHAN_NUM; c++) begin : g_chan
        assign acc[c+1] = acc[c] | (data[c*PROC_NUM +: PROC_NUM] & {PROC_NUM{vld[c]}});
    end

    assign merged = acc[CHAN_NUM];
endmodule

// File: rtl/dl_token_detect_unit.sv
// Per-process deadlock detector: arms after a sustained block, circulates its ID set and
// declares deadlock when its own ID returns; then relays the one-hot report token.
module dl_token_detect_unit
    import dl_pkg::*;
#(
    parameter int unsigned PROC_NUM     = 4,
    parameter int unsigned PROC_ID      = 0,
    parameter int unsigned CHAN_NUM     = 2,
    parameter int unsigned BLOCK_THRESH = 16
) (
    input logic                  clock,
    input logic                  reset,
    dl_token_detect_unit_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(BLOCK_THRESH + 1);
    localparam logic [CNT_W-1:0]    THRESH = CNT_W'(BLOCK_THRESH);
    localparam logic [PROC_NUM-1:0] OWN_ID = PROC_NUM'(onehot(PROC_ID, PROC_NUM));

    dl_state_e           state;
    logic [CNT_W-1:0]    cnt;
    logic [PROC_NUM-1:0] tok;
    logic [CHAN_NUM-1:0] dep_reg;
    logic                rpt_org;

    logic [PROC_NUM-1:0] merged;
    logic                blk;
    logic [CNT_W-1:0]    cnt_inc;
    logic                own_hit;
    logic                org_hit;
    logic                rpt_hit;
    logic [CHAN_NUM-1:0] rpt_dir;

    dl_chan_merge #(
        .PROC_NUM (PROC_NUM),
        .CHAN_NUM (CHAN_NUM)
    ) u_merge (
        .vld    (bus.token_in_vld),
        .data   (bus.token_in_data),
        .merged (merged)
    );

    assign blk     = bus.proc_blocked && (|bus.dep_vec);
    assign cnt_inc = cnt + CNT_W'(1);
    assign own_hit = |(merged & OWN_ID);
    assign org_hit = |(bus.origin & OWN_ID);
    assign rpt_hit = |bus.rpt_in_vld;
    assign rpt_dir = CHAN_NUM'(lowest_bit(FN_W'(dep_reg)));

    // FSM with registered outputs; report pulses default low every cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            state              <= IDLE;
            cnt                <= '0;
            tok                <= '0;
            dep_reg            <= '0;
            rpt_org            <= 1'b0;
            bus.token_out_vld  <= '0;
            bus.token_out_data <= '0;
            bus.rpt_out_vld    <= '0;
            bus.dl_detect_out  <= 1'b0;
        end else begin
            bus.rpt_out_vld   <= '0;
            bus.dl_detect_out <= 1'b0;
            case (state)
                // cnt is 0 in IDLE, so the same increment path covers both states
                IDLE, WAIT: begin
                    if (!blk) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt_inc >= THRESH) begin
                        state              <= ARMED;
                        cnt                <= THRESH;
                        dep_reg            <= bus.dep_vec;
                        tok                <= OWN_ID;
                        bus.token_out_vld  <= bus.dep_vec;
                        bus.token_out_data <= OWN_ID;
                    end else begin
                        state <= WAIT;
                        cnt   <= cnt_inc;
                    end
                end
                ARMED: begin
                    if (own_hit) begin
                        state              <= DETECTED;
                        tok                <= tok | merged;
                        bus.token_out_data <= tok | merged;
                        bus.dl_detect_out  <= 1'b1;
                    end else if (!bus.proc_blocked || (bus.dep_vec != dep_reg)) begin
                        state              <= IDLE;
                        cnt                <= '0;
                        tok                <= '0;
                        bus.token_out_vld  <= '0;
                        bus.token_out_data <= '0;
                    end else begin
                        tok                <= tok | merged;
                        bus.token_out_data <= tok | merged;
                    end
                end
                DETECTED: begin
                    tok                <= tok | merged;
                    bus.token_out_data <= tok | merged;
                    // injection and forwarding share one channel, hence a single pulse
                    if (org_hit || (rpt_hit && !rpt_org)) begin
                        bus.rpt_out_vld <= rpt_dir;
                    end
                    bus.dl_detect_out <= rpt_hit;
                    rpt_org           <= (rpt_org && !bus.token_clear) || org_hit;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dl_token_detect_unit.sv
// Scoreboard bench: bench acts as the peers, a behavioural model queues expected outputs.
module tb_dl_token_detect_unit;
    localparam int unsigned PN  = 4;
    localparam int unsigned CN  = 2;
    localparam int unsigned TH  = 4;
    localparam int unsigned PID = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    dl_token_detect_unit_if #(.PROC_NUM(PN), .CHAN_NUM(CN)) bus ();

    dl_token_detect_unit #(
        .PROC_NUM     (PN),
        .PROC_ID      (PID),
        .CHAN_NUM     (CN),
        .BLOCK_THRESH (TH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int            cyc;
        logic [CN-1:0] tov;
        logic [PN-1:0] tod;
        logic [CN-1:0] rpt;
        logic          det;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    // reference model: run length of blocked cycles, mode flags, collected ID set
    int            m_run   = 0;
    bit            m_armed = 0;
    bit            m_det   = 0;
    bit            m_org   = 0;
    logic [PN-1:0] m_seen  = '0;
    logic [CN-1:0] m_snap  = '0;
    logic [CN-1:0] d_cur   = 2'b01;

    function automatic logic [CN-1:0] first_chan(input logic [CN-1:0] v);
        logic [CN-1:0] r;
        r = '0;
        for (int i = CN - 1; i >= 0; i--) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    endtask

    task automatic model_update(input bit rst_n, input bit b, input logic [CN-1:0] d,
                                input logic [CN-1:0] tiv, input logic [CN*PN-1:0] tid,
                                input logic [CN-1:0] riv, input logic [PN-1:0] orig, input bit clr);
        logic [PN-1:0] m;
        logic [CN-1:0] rexp;
        bit            pulse;
        exp_t          e;
        m     = '0;
        rexp  = '0;
        pulse = 0;
        for (int c = 0; c < CN; c++) if (tiv[c]) m |= tid[c*PN +: PN];
        if (!rst_n) begin
            m_run = 0; m_armed = 0; m_det = 0; m_org = 0; m_seen = '0; m_snap = '0;
        end else if (m_det) begin
            m_seen |= m;
            if (orig[PID] || ((riv != 0) && !m_org)) rexp = first_chan(m_snap);
            pulse = (riv != 0);
            m_org = (m_org && !clr) || orig[PID];
        end else if (m_armed) begin
            if (m[PID]) begin
                m_det = 1; m_armed = 0; pulse = 1; m_seen |= m;
            end else if (!b || d != m_snap) begin
                m_armed = 0; m_seen = '0; m_run = 0;
            end else begin
                m_seen |= m;
            end
        end else if (b && d != 0) begin
            m_run++;
            if (m_run >= TH) begin
                m_armed = 1; m_snap = d; m_seen = '0; m_seen[PID] = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        e.cyc = cyc;
        e.tov = (m_armed || m_det) ? m_snap : '0;
        e.tod = (m_armed || m_det) ? m_seen : '0;
        e.rpt = rexp;
        e.det = pulse;
        if (e.tov != 0 || e.tod != 0 || e.rpt != 0 || e.det) sb.push_back(e);
    endtask

    task automatic step(input bit rst_n, input bit b, input logic [CN-1:0] d,
                        input logic [CN-1:0] tiv, input logic [CN*PN-1:0] tid,
                        input logic [CN-1:0] riv, input logic [PN-1:0] orig, input bit clr);
        reset             = rst_n;
        bus.proc_blocked  = b;
        bus.dep_vec       = d;
        bus.token_in_vld  = tiv;
        bus.token_in_data = tid;
        bus.rpt_in_vld    = riv;
        bus.origin        = orig;
        bus.token_clear   = clr;
        @(posedge clock);
        cyc++;
        model_update(rst_n, b, d, tiv, tid, riv, orig, clr);
        #1;
    endtask

    // monitor: whenever the DUT presents any output activity, pop and compare
    always @(negedge clock) begin
        logic [15:0] act;
        exp_t        e;
        if (cyc > 0) begin
            act = 16'({bus.token_out_vld, bus.token_out_data, bus.rpt_out_vld, bus.dl_detect_out});
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                $display("FAIL missed_output: expected activity at cycle %0d absent (now %0d)", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
            if (act != 0) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    check("unexpected_output", act, 16'h0);
                end else begin
                    e = sb.pop_front();
                    check("outputs", act, 16'({e.tov, e.tod, e.rpt, e.det}));
                end
            end
        end
    end

    initial begin
        logic [CN*PN-1:0] tid;
        logic [PN-1:0]    orig;
        bit               rst_n, b, clr;
        logic [CN-1:0]    tiv, riv;
        int               r;

        step(0, 0, 2'b00, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        step(0, 0, 2'b00, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        check("reset_outputs", 16'({bus.token_out_vld, bus.token_out_data, bus.rpt_out_vld, bus.dl_detect_out}), 16'h0);

        // block for three cycles then drop: must not arm
        repeat (3) step(1, 1, 2'b01, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        step(1, 0, 2'b01, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        // arm on the fourth blocked cycle, then merge foreign IDs 0110
        repeat (4) step(1, 1, 2'b01, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        step(1, 1, 2'b01, 2'b01, 8'h06, 2'b00, 4'h0, 0);
        step(1, 1, 2'b01, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        // dependency change drops back to IDLE
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        // re-arm on channel 1, own ID returns on channel 1
        repeat (4) step(1, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        step(1, 1, 2'b10, 2'b10, 8'h30, 2'b00, 4'h0, 0);
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        // report: inject, walk returns (no forward), clear, foreign walk (forward), overlap
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h1, 0);
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b01, 4'h0, 0);
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h0, 1);
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b10, 4'h0, 0);
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b01, 4'h1, 0);
        step(1, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        // reset while detected with rpt_org set, then a full re-arm is needed
        step(0, 1, 2'b10, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        check("reset_mid_detected", 16'({bus.token_out_vld, bus.token_out_data, bus.rpt_out_vld, bus.dl_detect_out}), 16'h0);
        repeat (5) step(1, 1, 2'b01, 2'b00, 8'h00, 2'b01, 4'h1, 0);

        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            b     = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 15) == 0) d_cur = CN'($urandom_range(0, 3));
            tiv = CN'($urandom_range(0, 3));
            tid = 8'($urandom);
            for (int c = 0; c < CN; c++)
                if ($urandom_range(0, 23) != 0) tid[c*PN + PID] = 1'b0;
            riv = ($urandom_range(0, 5) == 0) ? CN'($urandom_range(1, 3)) : '0;
            r   = $urandom_range(0, 9);
            orig = (r == 0) ? 4'h1 : (r == 1) ? PN'(4'h1 << $urandom_range(1, 3)) : 4'h0;
            clr = ($urandom_range(0, 9) == 0);
            step(rst_n, b, d_cur, tiv, tid, riv, orig, clr);
        end

        repeat (2) step(0, 0, 2'b00, 2'b00, 8'h00, 2'b00, 4'h0, 0);
        @(negedge clock);
        #1;
        check("scoreboard_drain", 16'(sb.size()), 16'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
